// File: rtl/swo_source_arb.sv
// swo_source_arb: picks one SWO byte decoder (Manchester or UART/NRZ), by
// forced mode or by automatic lock-on, and queues its bytes in a small FIFO
// for the trace packet layer. Reports lock state, overflow and drop count.
module swo_source_arb #(
    parameter int TIMEOUT_W  = 20,
    parameter int LOCK_BYTES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic [TIMEOUT_W-1:0] idleTicks,
    input  logic                 manchAvail,
    input  logic [7:0]           manchByte,
    input  logic                 uartAvail,
    input  logic [7:0]           uartByte,
    output logic                 outValid,
    output logic [7:0]           outByte,
    input  logic                 outReady,
    output logic [1:0]           activeSrc,
    output logic                 overflow,
    output logic [15:0]          dropCount
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LOCK_B = 4'(LOCK_BYTES);
    localparam logic [TIMEOUT_W-1:0] T_ZERO = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] T_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CAND_M = 3'd1,
        ST_CAND_U = 3'd2,
        ST_LOCK_M = 3'd3,
        ST_LOCK_U = 3'd4
    } state_t;

    state_t               state_r, state_s;
    logic                 prev_m_r, prev_u_r;
    logic [1:0]           mode_r;
    logic [3:0]           cand_cnt_r, cand_cnt_s;
    logic [TIMEOUT_W-1:0] idle_cnt_r, idle_cnt_s;
    logic [AW:0]          wr_ptr_r, rd_ptr_r;
    logic [7:0]           mem_r [FIFO_DEPTH];
    logic                 out_valid_r;
    logic [7:0]           out_byte_r;
    logic [1:0]           active_src_r;
    logic                 overflow_r;
    logic [15:0]          drop_count_r;

    logic                 ev_m_s, ev_u_s, mode_chg_s;
    logic [TIMEOUT_W-1:0] idle_inc_s;
    logic                 timeout_s;
    logic                 push_req_s, push_s, pop_s, drop_s, full_s;
    logic [7:0]           in_byte_s;
    logic [AW:0]          wr_ptr_s, rd_ptr_s;
    logic [7:0]           head_s;
    logic [1:0]           active_src_s;

    assign ev_m_s     = manchAvail ^ prev_m_r;
    assign ev_u_s     = uartAvail ^ prev_u_r;
    assign mode_chg_s = (mode != mode_r);
    assign idle_inc_s = (&idle_cnt_r) ? idle_cnt_r : idle_cnt_r + T_ONE;
    // Timeout fires on the edge at which the counter reaches idleTicks.
    assign timeout_s  = (idleTicks != T_ZERO) && (idle_inc_s == idleTicks);

    // Next-state logic for source selection, candidate and idle counters.
    always_comb begin
        state_s    = state_r;
        cand_cnt_s = cand_cnt_r;
        idle_cnt_s = idle_cnt_r;
        if (mode_chg_s) begin
            cand_cnt_s = 4'd0;
            idle_cnt_s = T_ZERO;
            case (mode)
                2'd1:    state_s = ST_LOCK_M;
                2'd2:    state_s = ST_LOCK_U;
                default: state_s = ST_IDLE;
            endcase
        end else begin
            case (mode)
                2'd1: state_s = ST_LOCK_M;
                2'd2: state_s = ST_LOCK_U;
                2'd3: begin
                    case (state_r)
                        ST_IDLE: begin
                            idle_cnt_s = T_ZERO;
                            if (ev_m_s && !ev_u_s) begin
                                cand_cnt_s = 4'd1;
                                state_s    = (LOCK_B == 4'd1) ? ST_LOCK_M : ST_CAND_M;
                            end else if (ev_u_s && !ev_m_s) begin
                                cand_cnt_s = 4'd1;
                                state_s    = (LOCK_B == 4'd1) ? ST_LOCK_U : ST_CAND_U;
                            end else begin
                                cand_cnt_s = 4'd0;
                            end
                        end
                        ST_CAND_M, ST_CAND_U: begin
                            if ((state_r == ST_CAND_M) ? ev_u_s : ev_m_s) begin
                                state_s    = ST_IDLE;
                                cand_cnt_s = 4'd0;
                                idle_cnt_s = T_ZERO;
                            end else if ((state_r == ST_CAND_M) ? ev_m_s : ev_u_s) begin
                                idle_cnt_s = T_ZERO;
                                if (cand_cnt_r + 4'd1 == LOCK_B) begin
                                    cand_cnt_s = 4'd0;
                                    state_s    = (state_r == ST_CAND_M) ? ST_LOCK_M : ST_LOCK_U;
                                end else begin
                                    cand_cnt_s = cand_cnt_r + 4'd1;
                                end
                            end else if (timeout_s) begin
                                state_s    = ST_IDLE;
                                cand_cnt_s = 4'd0;
                                idle_cnt_s = T_ZERO;
                            end else begin
                                idle_cnt_s = idle_inc_s;
                            end
                        end
                        ST_LOCK_M, ST_LOCK_U: begin
                            if ((state_r == ST_LOCK_M) ? ev_m_s : ev_u_s) begin
                                idle_cnt_s = T_ZERO;
                            end else if (timeout_s) begin
                                state_s    = ST_IDLE;
                                idle_cnt_s = T_ZERO;
                            end else begin
                                idle_cnt_s = idle_inc_s;
                            end
                        end
                        default: begin
                            state_s    = ST_IDLE;
                            cand_cnt_s = 4'd0;
                            idle_cnt_s = T_ZERO;
                        end
                    endcase
                end
                default: begin
                    state_s    = ST_IDLE;
                    cand_cnt_s = 4'd0;
                    idle_cnt_s = T_ZERO;
                end
            endcase
        end
    end

    // FIFO control: push/pop/drop decisions, next pointers and next head byte.
    always_comb begin
        push_req_s = 1'b0;
        in_byte_s  = 8'd0;
        if (!mode_chg_s && (state_r == ST_LOCK_M) && ev_m_s) begin
            push_req_s = 1'b1;
            in_byte_s  = manchByte;
        end else if (!mode_chg_s && (state_r == ST_LOCK_U) && ev_u_s) begin
            push_req_s = 1'b1;
            in_byte_s  = uartByte;
        end else begin
            push_req_s = 1'b0;
        end
        full_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        pop_s  = out_valid_r & outReady;
        push_s = push_req_s & (~full_s | pop_s);
        drop_s = push_req_s & full_s & ~pop_s;
        if (mode_chg_s) begin
            wr_ptr_s = '0;
            rd_ptr_s = '0;
            head_s   = 8'd0;
        end else begin
            wr_ptr_s = wr_ptr_r + {{AW{1'b0}}, push_s};
            rd_ptr_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
            // A byte pushed into an (effectively) empty FIFO becomes the head at once.
            if (push_s && (rd_ptr_s == wr_ptr_r)) begin
                head_s = in_byte_s;
            end else begin
                head_s = mem_r[rd_ptr_s[AW-1:0]];
            end
        end
        case (state_s)
            ST_LOCK_M: active_src_s = 2'd1;
            ST_LOCK_U: active_src_s = 2'd2;
            default:   active_src_s = 2'd0;
        endcase
    end

    // Control state, pointers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            prev_m_r     <= 1'b0;
            prev_u_r     <= 1'b0;
            mode_r       <= 2'd0;
            cand_cnt_r   <= 4'd0;
            idle_cnt_r   <= T_ZERO;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            out_valid_r  <= 1'b0;
            out_byte_r   <= 8'd0;
            active_src_r <= 2'd0;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'd0;
        end else begin
            state_r      <= state_s;
            prev_m_r     <= manchAvail;
            prev_u_r     <= uartAvail;
            mode_r       <= mode;
            cand_cnt_r   <= cand_cnt_s;
            idle_cnt_r   <= idle_cnt_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            out_valid_r  <= (wr_ptr_s != rd_ptr_s);
            out_byte_r   <= head_s;
            active_src_r <= active_src_s;
            if (mode_chg_s) begin
                overflow_r   <= 1'b0;
                drop_count_r <= 16'd0;
            end else if (drop_s) begin
                overflow_r   <= 1'b1;
                drop_count_r <= (drop_count_r == 16'hFFFF) ? drop_count_r : drop_count_r + 16'd1;
            end else begin
                overflow_r   <= overflow_r;
                drop_count_r <= drop_count_r;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= in_byte_s;
        end
    end

    assign outValid  = out_valid_r;
    assign outByte   = out_byte_r;
    assign activeSrc = active_src_r;
    assign overflow  = overflow_r;
    assign dropCount = drop_count_r;

endmodule
